regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
Parametrised multi-port register file for the RISC-V datapath, generalising the fixed 32x32, two-read-port file. It adds an architectural zero register, write-to-read bypass, and a per-register busy scoreboard with a pending-write counter. The scoreboard lets the decode stage detect RAW hazards against in-flight writebacks. It sits between decode (reads and allocation) and writeback (writes).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; depth = 2**ADDR_W
NUM_RD, 2, number of independent read ports (1..4)
ZERO_REG, 1, 1 = register 0 hardwired to zero, never busy
BYPASS, 1, 1 = same-cycle write data and busy-clear are visible on read ports

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high; clears all registers and the scoreboard
wr_en  input  1  writeback strobe
wr_addr  input  ADDR_W  writeback destination
wr_data  input  DATA_W  writeback data
alloc_en  input  1  decode marks a destination as pending
alloc_addr  input  ADDR_W  destination being allocated
rd_addr  input  NUM_RD*ADDR_W  packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
rd_data  output  NUM_RD*DATA_W  packed read data, combinational
rd_busy  output  NUM_RD  per-port busy flag for the addressed register, combinational
busy_cnt  output  ADDR_W+1  number of registers currently marked busy, registered

Behaviour:
- Clock and reset: clock is clk; reset is reset, asynchronous, active-high.
- Reset state: every register = 0, every busy bit = 0, busy_cnt = 0. While reset is high: rd_data = 0, rd_busy = 0. Reset takes precedence over wr_en and alloc_en in the same cycle.
- Write: on a rising clk edge with wr_en=1, mem[wr_addr] <= wr_data. Single cycle, no handshake.
- Zero register: when ZERO_REG=1, writes and allocs to address 0 are ignored. Reads of address 0 return 0 with rd_busy=0.
- Read: purely combinational, zero latency, and independent per port. Any number of ports may read the same address.
- Bypass (BYPASS=1): if wr_en=1 and wr_addr==rd_addr[k] (nonzero when ZERO_REG=1), then rd_data[k] = wr_data and rd_busy[k] = 0 in that cycle.
- No bypass (BYPASS=0): reads return the stored value and stored busy bit; the new value is visible from the next cycle.
- Scoreboard, per edge with address a:
  - Write-only to a: busy[a] <= 0.
  - Alloc-only to a: busy[a] <= 1.
  - Write and alloc to the same a: busy[a] <= 1. The new producer wins; the data is still written.
  - Write and alloc to different addresses: both apply.
  - Write to a non-busy register: legal; data is written and busy is unchanged.
  - Alloc to an already-busy register: legal; busy stays 1 with no double count.
- busy_cnt: registered and always equal to the popcount of the busy bits after the edge. It increments by +1 for each 0->1 transition and decrements by -1 for each 1->0 transition; a net 0 change leaves it unchanged.
- busy_cnt range: it never wraps. The maximum is 2**ADDR_W - ZERO_REG (31 at default), which is why the port is ADDR_W+1 bits wide.
- Reset mid-operation: busy bits and registers are lost immediately (asynchronous). Pending writebacks arriving after reset deassertion write data normally and clear nothing extra.
- Synthesis: the storage array is implemented as flops, not BRAM, because reads are asynchronous.

Test Plan:
- Reset then read all 32 addresses on both ports -> rd_data=0, rd_busy=0, busy_cnt=0.
- Write 0xDEADBEEF to x5; next cycle read x5 on port0 and port1 -> both 0xDEADBEEF. Write 0x12345678 to x0 -> x0 reads 0.
- BYPASS=1: wr_en to x7 with 0xA5A5A5A5 while rd_addr0=7 in the same cycle -> rd_data0=0xA5A5A5A5 combinationally. Repeat with BYPASS=0 -> old value that cycle, new value the next cycle.
- Alloc x3, x4, x3 on successive cycles -> busy_cnt 1, 2, 2, and rd_busy high for x3. Write x3 -> rd_busy for x3 drops in the write cycle (BYPASS=1) and busy_cnt=1 after the edge.
- Same-edge alloc and write to x9 while x9 is busy -> x9 stays busy, data updated, busy_cnt unchanged. Same-edge write x9 and alloc x10 -> busy_cnt unchanged net, x9 clear, x10 busy.
- Alloc all 31 nonzero registers -> busy_cnt=31. Assert reset asynchronously mid-cycle -> busy_cnt=0, all rd_busy=0, and all data 0 before the next clk edge.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised multi-port register file with an architectural
// zero register, optional write-to-read bypass and a per-register busy
// scoreboard carrying a registered count of pending writebacks.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     alloc_en,
  input  logic [ADDR_W-1:0]        alloc_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam bit          HAS_ZERO = (ZERO_REG != 0);
  localparam bit          HAS_BYPASS = (BYPASS != 0);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_next;
  logic [ADDR_W:0]   cnt_next;
  logic              wr_ok;
  logic              alloc_ok;
  logic              rise;
  logic              fall;

  // Requests targeting the hardwired zero register are dropped here.
  assign wr_ok    = wr_en    && !(HAS_ZERO && (wr_addr    == '0));
  assign alloc_ok = alloc_en && !(HAS_ZERO && (alloc_addr == '0));

  // Register storage: flops, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Next scoreboard state; alloc is applied after write so a same-address
  // pair leaves the register busy. The count moves only on real transitions.
  always_comb begin
    busy_next = busy;
    cnt_next  = busy_cnt;
    rise      = alloc_ok && !busy[alloc_addr];
    fall      = wr_ok && busy[wr_addr] && !(alloc_ok && (alloc_addr == wr_addr));
    if (wr_ok) begin
      busy_next[wr_addr] = 1'b0;
    end
    if (alloc_ok) begin
      busy_next[alloc_addr] = 1'b1;
    end
    if (rise && !fall) begin
      cnt_next = busy_cnt + (ADDR_W+1)'(1);
    end else if (fall && !rise) begin
      cnt_next = busy_cnt - (ADDR_W+1)'(1);
    end
  end

  // Scoreboard bits and pending-write count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_next;
      busy_cnt <= cnt_next;
    end
  end

  // Combinational read ports with zero-register masking and optional bypass.
  always_comb begin
    logic [ADDR_W-1:0] a;
    a       = '0;
    rd_data = '0;
    rd_busy = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      a = rd_addr[k*ADDR_W +: ADDR_W];
      if (reset) begin
        rd_data[k*DATA_W +: DATA_W] = '0;
        rd_busy[k]                  = 1'b0;
      end else if (HAS_ZERO && (a == '0)) begin
        rd_data[k*DATA_W +: DATA_W] = '0;
        rd_busy[k]                  = 1'b0;
      end else if (HAS_BYPASS && wr_ok && (wr_addr == a)) begin
        rd_data[k*DATA_W +: DATA_W] = wr_data;
        rd_busy[k]                  = 1'b0;
      end else begin
        rd_data[k*DATA_W +: DATA_W] = mem[a];
        rd_busy[k]                  = busy[a];
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed scoreboard bench. The driver sets inputs just after
// each rising edge and queues expected outputs; the monitor pops and compares
// them on the following falling edge. Two instances share inputs: one with
// bypass, one without.
module tb_regfile_sb;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        alloc_en;
  logic [4:0]  alloc_addr;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data, rd_data_nb;
  logic [1:0]  rd_busy, rd_busy_nb;
  logic [5:0]  busy_cnt, busy_cnt_nb;

  // kind: 0 rd_data, 1 rd_busy, 2 busy_cnt (bypass instance); 3/4/5 same, no-bypass instance
  typedef struct {
    string       name;
    int          kind;
    int          port;
    logic [31:0] exp;
  } chk_t;

  chk_t q[$];
  int   checks = 0;
  int   errors = 0;

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_busy(rd_busy), .busy_cnt(busy_cnt)
  );

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .rd_addr(rd_addr),
    .rd_data(rd_data_nb), .rd_busy(rd_busy_nb), .busy_cnt(busy_cnt_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare every queued expectation against the outputs at negedge.
  initial begin
    chk_t        c;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        c = q.pop_front();
        case (c.kind)
          0: act = rd_data[c.port*32 +: 32];
          1: act = 32'(rd_busy[c.port]);
          2: act = 32'(busy_cnt);
          3: act = rd_data_nb[c.port*32 +: 32];
          4: act = 32'(rd_busy_nb[c.port]);
          default: act = 32'(busy_cnt_nb);
        endcase
        checks++;
        if (act !== c.exp) begin
          errors++;
          $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", c.name, act, c.exp, $time);
        end
      end
    end
  end

  task automatic expect_val(input string name, input int kind, input int port, input logic [31:0] v);
    chk_t c;
    c.name = name;
    c.kind = kind;
    c.port = port;
    c.exp  = v;
    q.push_back(c);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [4:0] a0, input logic [4:0] a1);
    wr_en    = 1'b0;
    alloc_en = 1'b0;
    rd_addr  = {a1, a0};
  endtask

  initial begin
    reset      = 1'b1;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    alloc_en   = 1'b0;
    alloc_addr = '0;
    rd_addr    = '0;
    tick();

    // Reset wins over a write; outputs forced to zero while reset is high.
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hFFFF_FFFF; rd_addr = {5'd5, 5'd5};
    expect_val("rst_rd0", 0, 0, 32'h0);
    expect_val("rst_busy0", 1, 0, 32'h0);
    expect_val("rst_cnt", 2, 0, 32'h0);
    expect_val("rst_cnt_nb", 5, 0, 32'h0);
    tick();
    reset = 1'b0;

    // All addresses read zero and not busy after reset.
    for (int a = 0; a < 32; a++) begin
      idle(5'(a), 5'(a));
      expect_val($sformatf("init_rd0_x%0d", a), 0, 0, 32'h0);
      expect_val($sformatf("init_rd1_x%0d", a), 0, 1, 32'h0);
      expect_val($sformatf("init_busy0_x%0d", a), 1, 0, 32'h0);
      expect_val($sformatf("init_busy1_x%0d", a), 1, 1, 32'h0);
      expect_val("init_cnt", 2, 0, 32'h0);
      tick();
    end

    // Plain write then read on both ports.
    idle(5'd0, 5'd0);
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
    tick();
    idle(5'd5, 5'd5);
    expect_val("x5_rd0", 0, 0, 32'hDEAD_BEEF);
    expect_val("x5_rd1", 0, 1, 32'hDEAD_BEEF);
    expect_val("x5_rd0_nb", 3, 0, 32'hDEAD_BEEF);
    tick();

    // Writes to x0 are discarded, including on the bypass path.
    idle(5'd0, 5'd0);
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234_5678;
    expect_val("x0_byp_rd0", 0, 0, 32'h0);
    tick();
    idle(5'd0, 5'd0);
    expect_val("x0_rd0", 0, 0, 32'h0);
    expect_val("x0_rd1_nb", 3, 1, 32'h0);
    tick();

    // Same-cycle bypass versus stored value.
    idle(5'd7, 5'd5);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5_A5A5;
    expect_val("byp_x7_rd0", 0, 0, 32'hA5A5_A5A5);
    expect_val("nobyp_x7_old", 3, 0, 32'h0);
    expect_val("byp_x5_rd1", 0, 1, 32'hDEAD_BEEF);
    tick();
    idle(5'd7, 5'd5);
    expect_val("nobyp_x7_new", 3, 0, 32'hA5A5_A5A5);
    expect_val("byp_x7_after", 0, 0, 32'hA5A5_A5A5);
    tick();

    // Allocation sequence x3, x4, x3.
    idle(5'd0, 5'd0);
    alloc_en = 1'b1; alloc_addr = 5'd3;
    tick();
    idle(5'd3, 5'd0);
    alloc_en = 1'b1; alloc_addr = 5'd4;
    expect_val("alloc1_cnt", 2, 0, 32'd1);
    expect_val("alloc1_busy_x3", 1, 0, 32'd1);
    tick();
    idle(5'd3, 5'd0);
    alloc_en = 1'b1; alloc_addr = 5'd3;
    expect_val("alloc2_cnt", 2, 0, 32'd2);
    tick();
    idle(5'd3, 5'd4);
    expect_val("alloc3_cnt", 2, 0, 32'd2);
    expect_val("alloc3_cnt_nb", 5, 0, 32'd2);
    expect_val("alloc3_busy_x3", 1, 0, 32'd1);
    expect_val("alloc3_busy_x4", 1, 1, 32'd1);
    tick();

    // Writeback to busy x3 clears it.
    idle(5'd3, 5'd4);
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h0000_0033;
    expect_val("wb_x3_busy_byp", 1, 0, 32'd0);
    expect_val("wb_x3_busy_nb", 4, 0, 32'd1);
    expect_val("wb_x3_data_byp", 0, 0, 32'h33);
    expect_val("wb_x3_data_nb", 3, 0, 32'h0);
    expect_val("wb_x3_cnt_pre", 2, 0, 32'd2);
    tick();
    idle(5'd3, 5'd4);
    expect_val("wb_x3_cnt", 2, 0, 32'd1);
    expect_val("wb_x3_busy_after", 1, 0, 32'd0);
    expect_val("wb_x3_busy_after_nb", 4, 0, 32'd0);
    expect_val("wb_x3_data_after_nb", 3, 0, 32'h33);
    tick();

    // Same-edge write and alloc to busy x9.
    idle(5'd0, 5'd0);
    alloc_en = 1'b1; alloc_addr = 5'd9;
    tick();
    idle(5'd9, 5'd0);
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h0000_0099;
    alloc_en = 1'b1; alloc_addr = 5'd9;
    expect_val("wa_x9_cnt_pre", 2, 0, 32'd2);
    expect_val("wa_x9_busy_byp", 1, 0, 32'd0);
    expect_val("wa_x9_busy_nb", 4, 0, 32'd1);
    expect_val("wa_x9_data_byp", 0, 0, 32'h99);
    tick();
    idle(5'd9, 5'd0);
    expect_val("wa_x9_cnt", 2, 0, 32'd2);
    expect_val("wa_x9_busy", 1, 0, 32'd1);
    expect_val("wa_x9_data_nb", 3, 0, 32'h99);
    tick();

    // Write x9 and alloc x10 on the same edge: net count unchanged.
    idle(5'd9, 5'd10);
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h0000_009A;
    alloc_en = 1'b1; alloc_addr = 5'd10;
    tick();
    idle(5'd9, 5'd10);
    expect_val("wx9_ax10_cnt", 2, 0, 32'd2);
    expect_val("wx9_ax10_busy_x9", 1, 0, 32'd0);
    expect_val("wx9_ax10_busy_x10", 1, 1, 32'd1);
    expect_val("wx9_ax10_data_x9", 0, 0, 32'h9A);
    tick();

    // Alloc to x0 is ignored.
    idle(5'd0, 5'd0);
    alloc_en = 1'b1; alloc_addr = 5'd0;
    tick();
    idle(5'd0, 5'd0);
    expect_val("alloc_x0_cnt", 2, 0, 32'd2);
    expect_val("alloc_x0_busy", 1, 0, 32'd0);
    tick();

    // Fill the scoreboard.
    for (int a = 1; a < 32; a++) begin
      idle(5'd0, 5'd0);
      alloc_en = 1'b1; alloc_addr = 5'(a);
      tick();
    end
    idle(5'd0, 5'd31);
    alloc_en = 1'b1; alloc_addr = 5'd5;
    expect_val("full_cnt", 2, 0, 32'd31);
    expect_val("full_cnt_nb", 5, 0, 32'd31);
    expect_val("full_busy_x31", 1, 1, 32'd1);
    expect_val("full_busy_x0", 1, 0, 32'd0);
    tick();
    idle(5'd7, 5'd31);
    expect_val("full_realloc_cnt", 2, 0, 32'd31);
    tick();

    // Asynchronous reset mid-cycle, with a concurrent write that must not land.
    idle(5'd5, 5'd31);
    #1;
    reset = 1'b1;
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h0000_0055;
    expect_val("arst_cnt", 2, 0, 32'd0);
    expect_val("arst_cnt_nb", 5, 0, 32'd0);
    expect_val("arst_busy0", 1, 0, 32'd0);
    expect_val("arst_busy1", 1, 1, 32'd0);
    expect_val("arst_rd0", 0, 0, 32'h0);
    expect_val("arst_rd1_nb", 3, 1, 32'h0);
    tick();
    reset = 1'b0;
    idle(5'd5, 5'd7);
    expect_val("post_rst_x5", 0, 0, 32'h0);
    expect_val("post_rst_x7", 0, 1, 32'h0);
    expect_val("post_rst_cnt", 2, 0, 32'd0);
    tick();

    // Late writeback after reset: data lands, scoreboard untouched.
    idle(5'd0, 5'd0);
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h0000_0077;
    tick();
    idle(5'd9, 5'd0);
    expect_val("late_wb_data", 0, 0, 32'h77);
    expect_val("late_wb_busy", 1, 0, 32'd0);
    expect_val("late_wb_cnt", 2, 0, 32'd0);
    tick();

    // Bounded drain of the expectation queue.
    for (int i = 0; i < 4 && q.size() > 0; i++) begin
      @(posedge clk);
    end
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
